mux_cfg_seq_icc: RTL

MUX_CFG_SEQ_ICC -- requirements
Module: mux_cfg_seq_icc

---
 rtl/mux_cfg_seq_icc.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mux_cfg_seq_icc.sv
// mux_cfg_seq_icc
// Serial configuration loader for mux/sbox/clock-mux cells. A start pulse clears
// the configuration, NBITS data bits are shifted in MSB first, then one even-parity
// bit follows. A clean stream is committed to cbit/cbitb and program mode is
// released. A parity error parks the block in ERR with the cells held in program
// mode and a safe all-zero configuration.
// cbitb is kept as the exact complement of cbit on every cycle, because
// downstream cells resolve to X on any true/complement mismatch.
module mux_cfg_seq_icc #(
  parameter int unsigned NBITS = 48   // legal range 2..256
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  input  logic             sdata,
  input  logic             svalid,
  output logic             sready,
  output logic [NBITS-1:0] cbit,
  output logic [NBITS-1:0] cbitb,
  output logic             prog,
  output logic             busy,
  output logic             cfg_valid,
  output logic             err,
  output logic             done
);

  // Counter must reach NBITS (the parity-bit slot) without wrapping.
  localparam int unsigned   CW      = $clog2(NBITS + 2);
  localparam logic [CW-1:0] PAR_IDX = CW'(NBITS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_RELEASE = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  state_t           state_q,     state_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [NBITS-1:0] shreg_q,     shreg_d;
  logic             par_q,       par_d;
  logic [NBITS-1:0] cbit_q,      cbit_d;
  logic [NBITS-1:0] cbitb_q,     cbitb_d;
  logic             prog_q,      prog_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             err_q,       err_d;
  logic             done_q,      done_d;
  logic             sready_q,    sready_d;
  logic             busy_q,      busy_d;

  // Helper flags raised by the state decode, applied once after it.
  logic             drop_cfg;     // force program mode with the safe all-zero pattern
  logic             enter_clear;  // wipe load datapath and sticky error
  logic             bit_accept;

  // A bit moves only on the handshake; sready is registered and true only in LOAD.
  assign bit_accept = sready_q & svalid;

  // Next-state and next-output decode; all outputs come straight from flops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    cbit_d      = cbit_q;
    cbitb_d     = cbitb_q;
    prog_d      = prog_q;
    cfg_valid_d = cfg_valid_q;
    err_d       = err_q;
    done_d      = 1'b0;
    drop_cfg    = 1'b0;
    enter_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start together with abort is deliberately a no-op.
        if (start && !abort) begin
          state_d     = ST_CLEAR;
          drop_cfg    = 1'b1;
          enter_clear = 1'b1;
        end
      end

      ST_CLEAR: begin
        if (abort) begin
          state_d  = ST_IDLE;
          drop_cfg = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // abort wins over a bit accepted in the same cycle.
        if (abort) begin
          state_d  = ST_IDLE;
          drop_cfg = 1'b1;
        end else if (bit_accept) begin
          par_d = par_q ^ sdata;
          if (cnt_q == PAR_IDX) begin
            // Parity bit only folds into the running XOR; it is never shifted.
            state_d = ST_CHECK;
          end else begin
            shreg_d = {shreg_q[NBITS-2:0], sdata};
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
      end

      ST_CHECK: begin
        if (abort) begin
          state_d  = ST_IDLE;
          drop_cfg = 1'b1;
        end else if (!par_q) begin
          state_d = ST_COMMIT;
          cbit_d  = shreg_q;
          cbitb_d = ~shreg_q;
        end else begin
          state_d  = ST_ERR;
          err_d    = 1'b1;
          drop_cfg = 1'b1;
        end
      end

      // COMMIT and RELEASE cannot be interrupted once the pattern is on the cells.
      ST_COMMIT: begin
        state_d = ST_RELEASE;
      end

      ST_RELEASE: begin
        state_d     = ST_IDLE;
        prog_d      = 1'b0;
        cfg_valid_d = 1'b1;
        done_d      = 1'b1;
      end

      ST_ERR: begin
        // abort leaves err set so software can still see why the load failed.
        if (abort) begin
          state_d  = ST_IDLE;
          drop_cfg = 1'b1;
        end else if (start) begin
          state_d     = ST_CLEAR;
          drop_cfg    = 1'b1;
          enter_clear = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        drop_cfg = 1'b1;
      end
    endcase

    if (drop_cfg) begin
      prog_d      = 1'b1;
      cbit_d      = '0;
      cbitb_d     = '1;
      cfg_valid_d = 1'b0;
    end

    if (enter_clear) begin
      cnt_d   = '0;
      shreg_d = '0;
      par_d   = 1'b0;
      err_d   = 1'b0;
    end

    sready_d = (state_d == ST_LOAD);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and output registers; reset asserts asynchronously to a safe program-mode pattern.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      cbit_q      <= '0;
      cbitb_q     <= '1;
      prog_q      <= 1'b1;
      cfg_valid_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      sready_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      cbit_q      <= cbit_d;
      cbitb_q     <= cbitb_d;
      prog_q      <= prog_d;
      cfg_valid_q <= cfg_valid_d;
      err_q       <= err_d;
      done_q      <= done_d;
      sready_q    <= sready_d;
      busy_q      <= busy_d;
    end
  end

  assign sready    = sready_q;
  assign cbit      = cbit_q;
  assign cbitb     = cbitb_q;
  assign prog      = prog_q;
  assign busy      = busy_q;
  assign cfg_valid = cfg_valid_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule
